// File: rtl/i2c_mem_slave.sv
// I2C byte-memory slave: 7-bit device address, 1- or 2-byte register pointer,
// auto-incrementing sequential reads and writes over an oversampled bus.
module i2c_mem_slave #(
    parameter logic [6:0] DEV_ADDR    = 7'h50,
    parameter int         ADDR_BYTES  = 1,
    parameter int         DEPTH       = 256,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     scl_i,
    input  logic                     sda_i,
    output logic                     sda_oe_o,
    output logic                     busy_o,
    output logic                     wr_stb_o,
    output logic [$clog2(DEPTH)-1:0] wr_addr_o,
    output logic [7:0]               wr_data_o
);

    localparam int              AW         = $clog2(DEPTH);
    localparam logic [1:0]      LAST_ABYTE = 2'(ADDR_BYTES - 1);
    localparam logic [AW-1:0]   PTR_ONE    = {{(AW-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        IDLE, DEV, DEV_ACK, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_prev_q, sda_prev_q;
    logic                   scl_s, sda_s, scl_rise_s, scl_fall_s, start_s, stop_s;
    state_t                 state_q, state_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [6:0]             shift_q, shift_d;
    logic [7:0]             byte_s;
    logic                   rw_q, rw_d;
    logic [7:0]             addr_q, addr_d;
    logic [1:0]             abyte_q, abyte_d;
    logic [AW-1:0]          ptr_q, ptr_d;
    logic                   sda_oe_q, sda_oe_d, busy_q, busy_d, wr_stb_q, wr_stb_d;
    logic [AW-1:0]          wr_addr_q, wr_addr_d;
    logic [7:0]             wr_data_q, wr_data_d;
    logic                   mem_we_s;
    logic [7:0]             mem_q [DEPTH];
    logic [7:0]             rd_q;

    // Bus synchronisers plus one delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_q <= {SYNC_STAGES{1'b1}};
            sda_sync_q <= {SYNC_STAGES{1'b1}};
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s      = scl_sync_q[SYNC_STAGES-1];
    assign sda_s      = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise_s = scl_s & ~scl_prev_q;
    assign scl_fall_s = ~scl_s & scl_prev_q;
    assign start_s    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_s     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign byte_s     = {shift_q, sda_s};

    // Protocol state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= 4'd0;
            shift_q   <= 7'h00;
            rw_q      <= 1'b0;
            addr_q    <= 8'h00;
            abyte_q   <= 2'd0;
            ptr_q     <= {AW{1'b0}};
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= {AW{1'b0}};
            wr_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            abyte_q   <= abyte_d;
            ptr_q     <= ptr_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            wr_stb_q  <= wr_stb_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Single-port byte RAM: the pointer is the only address for both write and read
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[ptr_q] <= byte_s;
        end
        rd_q <= mem_q[ptr_q];
    end

    // Next-state logic; bit_cnt 8 marks the ACK slot start, 9 its second half
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        abyte_d   = abyte_q;
        ptr_d     = ptr_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        mem_we_s  = 1'b0;
        if (start_s) begin
            state_d   = DEV;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
        end else if (stop_s) begin
            state_d   = IDLE;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                DEV, ADDR, WDATA: begin
                    sda_oe_d = 1'b0;
                    if (scl_rise_s) begin
                        shift_d   = byte_s[6:0];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            case (state_q)
                                DEV: begin
                                    if (byte_s[7:1] == DEV_ADDR) begin
                                        state_d = DEV_ACK;
                                        rw_d    = byte_s[0];
                                        busy_d  = 1'b1;
                                        abyte_d = 2'd0;
                                        addr_d  = 8'h00;
                                    end else begin
                                        state_d = IGNORE;
                                    end
                                end
                                ADDR: begin
                                    state_d = ADDR_ACK;
                                    addr_d  = byte_s;
                                    if (abyte_q == LAST_ABYTE) begin
                                        ptr_d = AW'({addr_q, byte_s});
                                    end else begin
                                        ptr_d = ptr_q;
                                    end
                                end
                                WDATA: begin
                                    state_d   = WDATA_ACK;
                                    mem_we_s  = 1'b1;
                                    wr_stb_d  = 1'b1;
                                    wr_addr_d = ptr_q;
                                    wr_data_d = byte_s;
                                    ptr_d     = ptr_q + PTR_ONE;
                                end
                                default: state_d = IGNORE;
                            endcase
                        end else begin
                            state_d = state_q;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q;
                    end
                end
                DEV_ACK, ADDR_ACK, WDATA_ACK: begin
                    if (scl_fall_s) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            case (state_q)
                                DEV_ACK: begin
                                    if (rw_q) begin
                                        state_d  = RDATA;
                                        sda_oe_d = ~rd_q[7];
                                    end else begin
                                        state_d = ADDR;
                                    end
                                end
                                ADDR_ACK: begin
                                    abyte_d = abyte_q + 2'd1;
                                    state_d = (abyte_q == LAST_ABYTE) ? WDATA : ADDR;
                                end
                                default: state_d = WDATA;
                            endcase
                        end
                    end else if (scl_rise_s) begin
                        bit_cnt_d = 4'd9;
                    end else begin
                        bit_cnt_d = bit_cnt_q;
                    end
                end
                RDATA: begin
                    if (scl_rise_s) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            state_d = RDATA_ACK;
                            ptr_d   = ptr_q + PTR_ONE;
                        end else begin
                            state_d = RDATA;
                        end
                    end else if (scl_fall_s) begin
                        sda_oe_d = ~rd_q[~bit_cnt_q[2:0]];
                    end else begin
                        sda_oe_d = sda_oe_q;
                    end
                end
                RDATA_ACK: begin
                    if (scl_fall_s) begin
                        if (bit_cnt_q == 4'd9) begin
                            state_d   = RDATA;
                            bit_cnt_d = 4'd0;
                            sda_oe_d  = ~rd_q[7];
                        end else begin
                            sda_oe_d = 1'b0;
                        end
                    end else if (scl_rise_s) begin
                        if (!sda_s) begin
                            bit_cnt_d = 4'd9;
                        end else begin
                            state_d = IGNORE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q;
                    end
                end
                IDLE, IGNORE: sda_oe_d = 1'b0;
                default: begin
                    state_d  = IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    assign sda_oe_o  = sda_oe_q;
    assign busy_o    = busy_q;
    assign wr_stb_o  = wr_stb_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;

endmodule

// File: tb/tb_i2c_mem_slave.sv
// Bench for i2c_mem_slave: bit-banged master on a wired-AND bus shared by a
// default instance and a 2-byte-address, 1 KiB instance at device 0x52.
module tb_i2c_mem_slave;

    localparam int Q = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, scl, sda_m, sda_bus;
    logic       sda_oe0, busy0, wr_stb0;
    logic [7:0] wr_addr0, wr_data0;
    logic       sda_oe2, busy2, wr_stb2;
    logic [9:0] wr_addr2;
    logic [7:0] wr_data2;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_wr0[$];
    logic [31:0] exp_wr2[$];
    logic [31:0] exp_rd[$];
    logic [7:0]  mem0_m [256];
    logic [7:0]  ptr0_m;
    logic [7:0]  mem2_m [1024];
    logic [9:0]  ptr2_m;
    logic        watch, oe_seen, busy_seen;

    assign sda_bus = sda_m & ~sda_oe0 & ~sda_oe2;

    i2c_mem_slave dut0 (
        .clk(clk), .rst(rst), .scl_i(scl), .sda_i(sda_bus),
        .sda_oe_o(sda_oe0), .busy_o(busy0), .wr_stb_o(wr_stb0),
        .wr_addr_o(wr_addr0), .wr_data_o(wr_data0)
    );

    i2c_mem_slave #(.DEV_ADDR(7'h52), .ADDR_BYTES(2), .DEPTH(1024), .SYNC_STAGES(2)) dut2 (
        .clk(clk), .rst(rst), .scl_i(scl), .sda_i(sda_bus),
        .sda_oe_o(sda_oe2), .busy_o(busy2), .wr_stb_o(wr_stb2),
        .wr_addr_o(wr_addr2), .wr_data_o(wr_data2)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Write-strobe scoreboard and quiet-bus watcher
    always @(negedge clk) begin
        if (wr_stb0) begin
            if (exp_wr0.size() == 0) check_eq("wr0_spurious", 32'(exp_wr0.size()), 32'd1);
            else check_eq("wr0_strobe", {16'h0000, wr_addr0, wr_data0}, exp_wr0.pop_front());
        end
        if (wr_stb2) begin
            if (exp_wr2.size() == 0) check_eq("wr2_spurious", 32'(exp_wr2.size()), 32'd1);
            else check_eq("wr2_strobe", {14'h0000, wr_addr2, wr_data2}, exp_wr2.pop_front());
        end
        if (watch) begin
            oe_seen   <= oe_seen | sda_oe0;
            busy_seen <= busy_seen | busy0;
        end
    end

    task automatic bit_slot(input logic b, output logic rb);
        sda_m = b;    #Q;
        scl   = 1'b1; #Q;
        rb    = sda_bus; #Q;
        scl   = 1'b0; #Q;
    endtask

    task automatic send_start();
        sda_m = 1'b1; #Q;
        scl   = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        scl   = 1'b0; #Q;
    endtask

    task automatic send_stop();
        sda_m = 1'b0; #Q;
        scl   = 1'b1; #Q;
        sda_m = 1'b1; #Q;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_slot(b[i], r);
        bit_slot(1'b1, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d, output logic line);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_slot(1'b1, r);
            d[i] = r;
        end
        bit_slot(nack, line);
    endtask

    task automatic dev(input logic [7:0] b, input logic exp_ack);
        logic ack;
        write_byte(b, ack);
        check_eq("dev_ack", 32'(ack), exp_ack ? 32'd0 : 32'd1);
    endtask

    task automatic addr0(input logic [7:0] a);
        logic ack;
        write_byte(a, ack);
        check_eq("addr_ack", 32'(ack), 32'd0);
        ptr0_m = a;
    endtask

    task automatic addr2(input logic [15:0] a);
        logic ack;
        write_byte(a[15:8], ack);
        check_eq("addr2_hi_ack", 32'(ack), 32'd0);
        write_byte(a[7:0], ack);
        check_eq("addr2_lo_ack", 32'(ack), 32'd0);
        ptr2_m = a[9:0];
    endtask

    task automatic wdata0(input logic [7:0] d);
        logic ack;
        exp_wr0.push_back({16'h0000, ptr0_m, d});
        mem0_m[ptr0_m] = d;
        ptr0_m = ptr0_m + 8'd1;
        write_byte(d, ack);
        check_eq("wdata_ack", 32'(ack), 32'd0);
    endtask

    task automatic wdata2(input logic [7:0] d);
        logic ack;
        exp_wr2.push_back({14'h0000, ptr2_m, d});
        mem2_m[ptr2_m] = d;
        ptr2_m = ptr2_m + 10'd1;
        write_byte(d, ack);
        check_eq("wdata2_ack", 32'(ack), 32'd0);
    endtask

    task automatic rdata0(input logic nack);
        logic [7:0] d;
        logic       line;
        exp_rd.push_back({24'h000000, mem0_m[ptr0_m]});
        ptr0_m = ptr0_m + 8'd1;
        read_byte(nack, d, line);
        check_eq("rd0_data", {24'h000000, d}, exp_rd.pop_front());
        if (nack) check_eq("rd0_nack_release", 32'(line), 32'd1);
    endtask

    task automatic rdata2(input logic nack);
        logic [7:0] d;
        logic       line;
        exp_rd.push_back({24'h000000, mem2_m[ptr2_m]});
        ptr2_m = ptr2_m + 10'd1;
        read_byte(nack, d, line);
        check_eq("rd2_data", {24'h000000, d}, exp_rd.pop_front());
        if (nack) check_eq("rd2_nack_release", 32'(line), 32'd1);
    endtask

    initial begin
        logic ack, r;
        rst = 1'b1; scl = 1'b1; sda_m = 1'b1;
        watch = 1'b0; oe_seen = 1'b0; busy_seen = 1'b0;
        ptr0_m = 8'h00; ptr2_m = 10'h000;
        repeat (4) @(negedge clk);
        check_eq("rst_oe",      32'(sda_oe0),  32'd0);
        check_eq("rst_busy",    32'(busy0),    32'd0);
        check_eq("rst_stb",     32'(wr_stb0),  32'd0);
        check_eq("rst_wr_addr", 32'(wr_addr0), 32'd0);
        check_eq("rst_wr_data", 32'(wr_data0), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Basic two-byte write at 0x10
        send_start(); dev(8'hA0, 1'b1); addr0(8'h10);
        check_eq("busy_in_xfer", 32'(busy0), 32'd1);
        wdata0(8'h5A); wdata0(8'hC3);
        send_stop();
        check_eq("busy_after_stop", 32'(busy0), 32'd0);

        // Random read via repeated START, ACK then NACK
        send_start(); dev(8'hA0, 1'b1); addr0(8'h10);
        send_start(); dev(8'hA1, 1'b1);
        rdata0(1'b0); rdata0(1'b1);
        #Q;
        check_eq("oe_after_nack", 32'(sda_oe0), 32'd0);
        send_stop();

        // Wrong device address: bus stays untouched
        oe_seen = 1'b0; busy_seen = 1'b0; watch = 1'b1;
        send_start(); dev(8'hA2, 1'b0);
        write_byte(8'h10, ack);
        check_eq("wrong_dev_data_nack", 32'(ack), 32'd1);
        send_stop();
        watch = 1'b0;
        check_eq("wrong_dev_oe",   32'(oe_seen),   32'd0);
        check_eq("wrong_dev_busy", 32'(busy_seen), 32'd0);

        // Aborted byte leaves memory untouched
        send_start(); dev(8'hA0, 1'b1); addr0(8'h20); wdata0(8'h77); send_stop();
        send_start(); dev(8'hA0, 1'b1); addr0(8'h20);
        bit_slot(1'b1, r); bit_slot(1'b0, r); bit_slot(1'b0, r); bit_slot(1'b1, r);
        send_stop();
        send_start(); dev(8'hA0, 1'b1); addr0(8'h20);
        send_start(); dev(8'hA1, 1'b1); rdata0(1'b1); send_stop();

        // Reset while the slave drives a 0 data bit
        send_start(); dev(8'hA0, 1'b1); addr0(8'h00); wdata0(8'h0F); wdata0(8'h70); send_stop();
        send_start(); dev(8'hA0, 1'b1); addr0(8'h01);
        send_start(); dev(8'hA1, 1'b1);
        check_eq("rd_drive_zero", 32'(sda_oe0), 32'd1);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        check_eq("rst_release_oe", 32'(sda_oe0), 32'd0);
        check_eq("rst_busy_mid",   32'(busy0),   32'd0);
        rst = 1'b0; ptr0_m = 8'h00; ptr2_m = 10'h000;
        oe_seen = 1'b0; watch = 1'b1;
        bit_slot(1'b1, r); bit_slot(1'b1, r); bit_slot(1'b1, r);
        send_stop();
        watch = 1'b0;
        check_eq("ignore_after_rst", 32'(oe_seen), 32'd0);
        send_start(); dev(8'hA1, 1'b1); rdata0(1'b1); send_stop();

        // Two-byte addressing with pointer wrap on the 1 KiB instance
        send_start(); dev(8'hA4, 1'b1); addr2(16'h03FF); wdata2(8'h11); wdata2(8'h22); send_stop();
        send_start(); dev(8'hA4, 1'b1); addr2(16'h13FF);
        send_start(); dev(8'hA5, 1'b1); rdata2(1'b1); send_stop();

        repeat (10) @(negedge clk);
        check_eq("wr0_missing", 32'(exp_wr0.size()), 32'd0);
        check_eq("wr2_missing", 32'(exp_wr2.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
